// File: rtl/axis_pcap_arbiter.sv
// axis_pcap_arbiter
//   Packet-atomic round-robin merge of N_PORTS AXI4-Stream sources onto the
//   single pcap dumper stream. It also sequences capture shutdown: once
//   every source has declared itself done and traffic has drained for
//   EOS_DRAIN_CYCLES idle cycles, eos rises and stays high until reset.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   s_tdata/s_tstrb   packed source data/strobes, port k at slice k
//   s_tvalid/s_tlast  per-source valid / last
//   s_tready          per-source ready (only the granted port in BUSY)
//   s_done            per-source "no more packets", latched sticky
//   m_*               merged stream towards the dumper
//   grant             owning port index (meaningful while busy)
//   busy              a packet is in progress
//   pkt_count         packets forwarded, wraps at 16 bits
//   err_oversize      sticky, a packet exceeded MAX_PKT_BEATS beats
//   eos               end of stream level to the dumper
module axis_pcap_arbiter #(
    parameter int N_PORTS          = 4,
    parameter int AXIS_WIDTH       = 512,
    parameter int MAX_PKT_BEATS    = 64,
    parameter int EOS_DRAIN_CYCLES = 16
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [N_PORTS*AXIS_WIDTH-1:0]      s_tdata,
    input  logic [N_PORTS*AXIS_WIDTH/8-1:0]    s_tstrb,
    input  logic [N_PORTS-1:0]                 s_tvalid,
    input  logic [N_PORTS-1:0]                 s_tlast,
    output logic [N_PORTS-1:0]                 s_tready,
    input  logic [N_PORTS-1:0]                 s_done,
    output logic [AXIS_WIDTH-1:0]              m_tdata,
    output logic [AXIS_WIDTH/8-1:0]            m_tstrb,
    output logic                               m_tvalid,
    output logic                               m_tlast,
    input  logic                               m_tready,
    output logic [$clog2(N_PORTS)-1:0]         grant,
    output logic                               busy,
    output logic [15:0]                        pkt_count,
    output logic                               err_oversize,
    output logic                               eos
);

    localparam int GW  = $clog2(N_PORTS);
    localparam int SW  = AXIS_WIDTH / 8;
    localparam int BCW = $clog2(MAX_PKT_BEATS + 1);
    localparam int DCW = $clog2(EOS_DRAIN_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, BUSY, DRAIN, DONE} state_t;

    state_t           state_q, state_d;
    logic [GW-1:0]    last_grant;
    logic [GW-1:0]    pick;
    logic [GW-1:0]    idx;
    logic [N_PORTS-1:0] done_q;
    logic             done_all;
    logic [BCW-1:0]   beat_cnt;
    logic [DCW-1:0]   drain_cnt;
    logic             beat;
    logic             drain_end;

    // A port raising s_done in the same cycle counts immediately, so the
    // drain sequence can start without waiting a cycle for the latch.
    assign done_all  = &(done_q | s_done);
    assign busy      = (state_q == BUSY);
    assign beat      = busy && m_tvalid && m_tready;
    assign drain_end = (drain_cnt == DCW'(EOS_DRAIN_CYCLES - 1));

    // Round-robin search starting after last_grant. Iterating from the
    // farthest offset down lets the nearest requester overwrite the pick.
    always_comb begin
        pick = '0;
        idx  = '0;
        for (int i = N_PORTS; i >= 1; i--) begin
            idx = GW'((int'(last_grant) + i) % N_PORTS);
            if (s_tvalid[idx]) pick = idx;
        end
    end

    // Data path always follows slice [grant] so outputs never go X.
    always_comb begin
        m_tdata = s_tdata[0 +: AXIS_WIDTH];
        m_tstrb = s_tstrb[0 +: SW];
        m_tlast = s_tlast[0];
        for (int k = 0; k < N_PORTS; k++) begin
            if (grant == GW'(k)) begin
                m_tdata = s_tdata[k*AXIS_WIDTH +: AXIS_WIDTH];
                m_tstrb = s_tstrb[k*SW +: SW];
                m_tlast = s_tlast[k];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        m_tvalid = 1'b0;
        s_tready = '0;
        case (state_q)
            IDLE: begin
                if (|s_tvalid)              state_d = BUSY;
                else if (done_all && !eos)  state_d = DRAIN;
            end
            BUSY: begin
                m_tvalid        = s_tvalid[grant];
                s_tready[grant] = m_tready;
                if (m_tvalid && m_tready && m_tlast) state_d = IDLE;
            end
            DRAIN: begin
                if (|s_tvalid)      state_d = IDLE;
                else if (drain_end) state_d = DONE;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant        <= '0;
            last_grant   <= GW'(N_PORTS - 1);
            pkt_count    <= '0;
            err_oversize <= 1'b0;
            eos          <= 1'b0;
            done_q       <= '0;
            beat_cnt     <= '0;
            drain_cnt    <= '0;
        end else begin
            done_q <= done_q | s_done;

            if (state_q == IDLE && |s_tvalid) grant <= pick;

            if (beat) begin
                // beat_cnt holds beats already sent; it saturates at the
                // limit so an arbitrarily long packet keeps flagging.
                if (beat_cnt == BCW'(MAX_PKT_BEATS)) err_oversize <= 1'b1;
                if (m_tlast) begin
                    beat_cnt   <= '0;
                    last_grant <= grant;
                    pkt_count  <= pkt_count + 16'd1;
                end else if (beat_cnt != BCW'(MAX_PKT_BEATS)) begin
                    beat_cnt <= beat_cnt + BCW'(1);
                end
            end

            if (state_q == DRAIN) begin
                if (|s_tvalid) begin
                    drain_cnt <= '0;
                end else if (drain_end) begin
                    drain_cnt <= '0;
                    eos       <= 1'b1;
                end else begin
                    drain_cnt <= drain_cnt + DCW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_axis_pcap_arbiter.sv
module tb_axis_pcap_arbiter;

    localparam int NP   = 4;
    localparam int W    = 32;
    localparam int MAXB = 4;
    localparam int EDC  = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NP*W-1:0]   s_tdata = '0;
    logic [NP*W/8-1:0] s_tstrb = '0;
    logic [NP-1:0]     s_tvalid = '0;
    logic [NP-1:0]     s_tlast = '0;
    logic [NP-1:0]     s_tready;
    logic [NP-1:0]     s_done = '0;
    logic [W-1:0]      m_tdata;
    logic [W/8-1:0]    m_tstrb;
    logic              m_tvalid;
    logic              m_tlast;
    logic              m_tready = 1'b1;
    logic [1:0]        grant;
    logic              busy;
    logic [15:0]       pkt_count;
    logic              err_oversize;
    logic              eos;

    always #5 clk = ~clk;

    axis_pcap_arbiter #(
        .N_PORTS(NP), .AXIS_WIDTH(W), .MAX_PKT_BEATS(MAXB), .EOS_DRAIN_CYCLES(EDC)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .s_tdata(s_tdata), .s_tstrb(s_tstrb), .s_tvalid(s_tvalid),
        .s_tlast(s_tlast), .s_tready(s_tready), .s_done(s_done),
        .m_tdata(m_tdata), .m_tstrb(m_tstrb), .m_tvalid(m_tvalid),
        .m_tlast(m_tlast), .m_tready(m_tready),
        .grant(grant), .busy(busy), .pkt_count(pkt_count),
        .err_oversize(err_oversize), .eos(eos)
    );

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;
    int n_stall = 0;

    logic [31:0] obs_d[$];
    int          obs_c[$];
    logic        obs_l[$];

    int pkts_left[NP];
    int plen[NP];
    int bidx[NP];
    int pn[NP];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    // Beat payload: port in [27:24], packet number in [15:8], beat in [7:0]
    function automatic logic [31:0] mk(input int k, input int p, input int b);
        return 32'((k << 24) | (p << 8) | b);
    endfunction

    task automatic drive_srcs();
        for (int k = 0; k < NP; k++) begin
            s_tstrb[k*4 +: 4] = 4'hF;
            if (pkts_left[k] > 0) begin
                s_tvalid[k]       = 1'b1;
                s_tdata[k*W +: W] = mk(k, pn[k], bidx[k]);
                s_tlast[k]        = (bidx[k] == plen[k] - 1);
            end else begin
                s_tvalid[k]       = 1'b0;
                s_tlast[k]        = 1'b0;
                s_tdata[k*W +: W] = mk(k, 255, 255);
            end
        end
    endtask

    // One clock: set ready, observe, clock, advance the source models.
    task automatic step(input logic rdy);
        logic [NP-1:0] hs;
        logic [3:0]    oh;
        m_tready = rdy;
        #1;
        hs = s_tvalid & s_tready;
        if (m_tvalid && m_tready) begin
            obs_d.push_back(m_tdata);
            obs_c.push_back(cyc);
            obs_l.push_back(m_tlast);
            oh = 4'b0001 << m_tdata[25:24];
            check("ready_onehot", {28'd0, s_tready}, {28'd0, oh});
            check("strb", {28'd0, m_tstrb}, 32'hF);
        end else if (busy && !m_tready) begin
            n_stall++;
            check("stall_ready", {28'd0, s_tready}, 32'd0);
        end
        @(posedge clk);
        #1;
        cyc++;
        for (int k = 0; k < NP; k++) begin
            if (hs[k]) begin
                if (bidx[k] == plen[k] - 1) begin
                    bidx[k] = 0;
                    pn[k]++;
                    pkts_left[k]--;
                end else begin
                    bidx[k]++;
                end
            end
        end
        drive_srcs();
    endtask

    task automatic run_until(input int n, input int budget);
        int b;
        b = budget;
        while (obs_d.size() < n && b > 0) begin
            step(1'b1);
            b--;
        end
        check("beats_seen", obs_d.size(), n);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        for (int k = 0; k < NP; k++) begin
            pkts_left[k] = 0; plen[k] = 1; bidx[k] = 0; pn[k] = 0;
        end
        s_done   = '0;
        m_tready = 1'b1;
        drive_srcs();
        obs_d.delete(); obs_c.delete(); obs_l.delete();
        n_stall = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
    endtask

    int t0;
    int ep[10];
    int epk[10];

    initial begin
        // Reset values and single 3-beat packet from port 0
        do_reset();
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_grant", {30'd0, grant}, 32'd0);
        check("rst_pkt_count", {16'd0, pkt_count}, 32'd0);
        check("rst_err", {31'd0, err_oversize}, 32'd0);
        check("rst_eos", {31'd0, eos}, 32'd0);
        check("rst_m_tvalid", {31'd0, m_tvalid}, 32'd0);
        check("rst_s_tready", {28'd0, s_tready}, 32'd0);

        pkts_left[0] = 1; plen[0] = 3;
        drive_srcs();
        t0 = cyc;
        run_until(3, 10);
        check("t1_first_beat_cyc", obs_c[0], t0 + 1);
        check("t1_third_beat_cyc", obs_c[2], t0 + 3);
        check("t1_beat1", obs_d[1], mk(0, 0, 1));
        check("t1_beat2", obs_d[2], mk(0, 0, 2));
        check("t1_last_early", {31'd0, obs_l[1]}, 32'd0);
        check("t1_last", {31'd0, obs_l[2]}, 32'd1);
        check("t1_pkt_count", {16'd0, pkt_count}, 32'd1);
        check("t1_grant", {30'd0, grant}, 32'd0);
        check("t1_busy_after", {31'd0, busy}, 32'd0);

        // All four ports contend with 2-beat packets; port 0 has two
        do_reset();
        pkts_left = '{2, 1, 1, 1};
        plen      = '{2, 2, 2, 2};
        drive_srcs();
        run_until(10, 60);
        ep  = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0};
        epk = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 1};
        for (int j = 0; j < 10; j++)
            check("t2_order", obs_d[j], mk(ep[j], epk[j], j % 2));
        for (int j = 1; j < 10; j++)
            check("t2_spacing", obs_c[j] - obs_c[j-1], (j % 2 == 0) ? 2 : 1);
        check("t2_pkt_count", {16'd0, pkt_count}, 32'd5);

        // Backpressure 1,0,1,0 on a 4-beat packet from port 2
        do_reset();
        pkts_left[2] = 1; plen[2] = 4;
        drive_srcs();
        begin
            int i;
            i = 0;
            while (obs_d.size() < 4 && i < 30) begin
                step(i % 2 == 0);
                i++;
            end
        end
        check("t3_beats", obs_d.size(), 4);
        for (int j = 0; j < 4; j++)
            check("t3_data", obs_d[j], mk(2, 0, j));
        check("t3_stalls", n_stall, 4);

        // Oversize packet: 5 beats with a limit of 4, flag stays sticky
        do_reset();
        pkts_left[1] = 1; plen[1] = 5;
        drive_srcs();
        run_until(4, 20);
        check("t4_err_before", {31'd0, err_oversize}, 32'd0);
        run_until(5, 5);
        check("t4_err_after", {31'd0, err_oversize}, 32'd1);
        check("t4_beat5", obs_d[4], mk(1, 0, 4));
        check("t4_beat5_last", {31'd0, obs_l[4]}, 32'd1);
        pkts_left[2] = 1; plen[2] = 2;
        drive_srcs();
        run_until(7, 10);
        check("t4_err_sticky", {31'd0, err_oversize}, 32'd1);
        check("t4_pkt_count", {16'd0, pkt_count}, 32'd2);

        // All sources done, no traffic: eos after 1+EDC cycles, then terminal
        do_reset();
        s_done = '1;
        repeat (EDC) step(1'b1);
        check("t5_eos_early", {31'd0, eos}, 32'd0);
        step(1'b1);
        check("t5_eos", {31'd0, eos}, 32'd1);
        pkts_left[0] = 1; plen[0] = 1;
        drive_srcs();
        #1;
        check("t5_done_tvalid", {31'd0, m_tvalid}, 32'd0);
        check("t5_done_tready", {28'd0, s_tready}, 32'd0);
        step(1'b1);
        step(1'b1);
        check("t5_done_no_beats", obs_d.size(), 0);
        check("t5_eos_held", {31'd0, eos}, 32'd1);

        // Port 1 interrupts the drain; its packet is served, drain restarts
        do_reset();
        s_done = '1;
        step(1'b1);
        step(1'b1);
        pkts_left[1] = 1; plen[1] = 2;
        drive_srcs();
        run_until(2, 10);
        check("t5b_eos_no", {31'd0, eos}, 32'd0);
        check("t5b_beat0", obs_d[0], mk(1, 0, 0));
        repeat (EDC) step(1'b1);
        check("t5b_eos_early", {31'd0, eos}, 32'd0);
        step(1'b1);
        check("t5b_eos", {31'd0, eos}, 32'd1);

        // Reset in the middle of port 3's second packet
        do_reset();
        pkts_left[3] = 2; plen[3] = 4;
        drive_srcs();
        run_until(6, 20);
        check("t6_pkt_before", {16'd0, pkt_count}, 32'd1);
        check("t6_busy_before", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("t6_rst_tvalid", {31'd0, m_tvalid}, 32'd0);
        check("t6_rst_pkt", {16'd0, pkt_count}, 32'd0);
        check("t6_rst_eos", {31'd0, eos}, 32'd0);
        check("t6_rst_busy", {31'd0, busy}, 32'd0);
        check("t6_rst_tready", {28'd0, s_tready}, 32'd0);
        do_reset();
        pkts_left[0] = 1; pkts_left[3] = 1;
        drive_srcs();
        step(1'b1);
        check("t6_busy", {31'd0, busy}, 32'd1);
        check("t6_grant0", {30'd0, grant}, 32'd0);
        run_until(2, 10);
        check("t6_first", obs_d[0], mk(0, 0, 0));
        check("t6_second", obs_d[1], mk(3, 0, 0));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
